// File: rtl/counter_time_arbiter.sv
// counter_time_arbiter
//
// One WIDTH-bit up-counter shared between N requesters. A round-robin
// arbiter hands the counter to one requester at a time. The counter runs
// from 0 up to that requester's latched length. The block then returns a
// one-cycle DONE to the same requester.
//
// Ports
//   CLK    : clock, every state update happens on its rising edge
//   RESET  : synchronous, active-high reset
//   REQ    : per-requester request level (N bits)
//   LEN    : per-requester terminal count, slice i = LEN[i*WIDTH +: WIDTH]
//   GNT    : one-hot grant, high while the requester owns the counter
//   DONE   : one-hot, one-cycle completion pulse
//   O      : current counter value
//   COUT   : high while counting and O is all ones
//   BUSY   : high while in COUNT or FIN
module counter_time_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N-1:0]       REQ,
    input  logic [N*WIDTH-1:0] LEN,
    output logic [N-1:0]       GNT,
    output logic [N-1:0]       DONE,
    output logic [WIDTH-1:0]   O,
    output logic               COUT,
    output logic               BUSY
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, COUNT, FIN} state_t;

    state_t            state_reg,  state_next;
    logic [IW-1:0]     ptr_reg,    ptr_next;
    logic [IW-1:0]     winner_reg, winner_next;
    logic [WIDTH-1:0]  len_reg,    len_next;
    logic [WIDTH-1:0]  count_reg,  count_next;
    logic [N-1:0]      gnt_reg,    gnt_next;
    logic [N-1:0]      done_reg,   done_next;
    logic              busy_reg,   busy_next;

    logic [WIDTH-1:0]  len_slice [N];
    logic              arb_found;
    logic [IW-1:0]     arb_idx;
    logic [IW:0]       cand_wide;
    logic [IW-1:0]     cand;
    logic [IW-1:0]     winner_inc;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_len
            assign len_slice[gi] = LEN[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin scan: first set REQ bit starting at the pointer, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_wide = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand_wide = {1'b0, ptr_reg} + (IW+1)'(k);
            if (cand_wide >= (IW+1)'(N)) begin
                cand_wide = cand_wide - (IW+1)'(N);
            end
            cand = cand_wide[IW-1:0];
            if (!arb_found && REQ[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign winner_inc = (winner_reg == IW'(N-1)) ? '0 : winner_reg + IW'(1);

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        len_next    = len_reg;
        count_next  = '0;
        gnt_next    = '0;
        done_next   = '0;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next  = COUNT;
                    winner_next = arb_idx;
                    len_next    = len_slice[arb_idx];
                    gnt_next    = ONE << arb_idx;
                end
            end
            COUNT: begin
                // A dropped request aborts the interval and wins over completion.
                if (!REQ[winner_reg]) begin
                    state_next = IDLE;
                    ptr_next   = winner_inc;
                end else if (count_reg == len_reg) begin
                    state_next = FIN;
                    done_next  = ONE << winner_reg;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                    gnt_next   = gnt_reg;
                end
            end
            FIN: begin
                state_next = IDLE;
                ptr_next   = winner_inc;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            winner_reg <= '0;
            len_reg    <= '0;
            count_reg  <= '0;
            gnt_reg    <= '0;
            done_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            winner_reg <= winner_next;
            len_reg    <= len_next;
            count_reg  <= count_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign GNT  = gnt_reg;
    assign DONE = done_reg;
    assign O    = count_reg;
    assign BUSY = busy_reg;
    assign COUT = (state_reg == COUNT) && (&count_reg);

endmodule

// File: tb/tb_counter_time_arbiter.sv
// Testbench for counter_time_arbiter (N=4, WIDTH=4).
// Expected completions {requester, length} are queued when a request is
// driven; a monitor pops them on each DONE pulse and checks owner and
// grant length. Directed per-cycle checks cover timing, COUT, abort and reset.
module tb_counter_time_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           CLK;
    logic           RESET;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] LEN;
    logic [N-1:0]   GNT;
    logic [N-1:0]   DONE;
    logic [W-1:0]   O;
    logic           COUT;
    logic           BUSY;

    typedef struct {
        int idx;
        int len;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    counter_time_arbiter #(.N(N), .WIDTH(W)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .REQ  (REQ),
        .LEN  (LEN),
        .GNT  (GNT),
        .DONE (DONE),
        .O    (O),
        .COUT (COUT),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int idx, input int len);
        exp_t e;
        e.idx = idx;
        e.len = len;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a DONE pulse; returns at the negedge where it is seen.
    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (DONE != '0) seen = 1'b1;
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor.
    initial begin
        logic [N-1:0] prev_gnt;
        int           run;
        int           glen;
        exp_t         e;
        prev_gnt = '0;
        run      = 0;
        glen     = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_gnt = '0;
                run      = 0;
            end else begin
                check_eq("gnt_done_excl", 32'(GNT & DONE), 32'd0);
                if (GNT != '0) begin
                    if (prev_gnt == '0) run = 0;
                    else run++;
                    check_eq("o_ramp", 32'(O), 32'(run));
                    glen = run + 1;
                end
                if (DONE != '0) begin
                    if (sb.size() == 0) begin
                        check_eq("done_unexpected", 32'(DONE), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("done_owner", 32'(DONE), 32'd1 << e.idx);
                        check_eq("grant_len", 32'(glen), 32'(e.len + 1));
                        check_eq("done_follows_gnt", 32'(prev_gnt), 32'(DONE));
                        $display("txn: requester %0d len %0d grant %0d cycles done", e.idx, e.len, glen);
                    end
                end
                prev_gnt = GNT;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        REQ   = 4'b1111;
        LEN   = '0;

        // Test 1: reset with all requesting, then req0 wins first.
        push_exp(0, 0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge CLK);
            check_eq("rst_gnt", 32'(GNT), 32'd0);
            check_eq("rst_done", 32'(DONE), 32'd0);
            check_eq("rst_o", 32'(O), 32'd0);
            check_eq("rst_busy", 32'(BUSY), 32'd0);
        end
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        check_eq("rel_gnt", 32'(GNT), 32'd0);
        next_cycle();
        REQ = 4'b0001;
        @(negedge CLK);
        check_eq("first_gnt", 32'(GNT), 32'b0001);
        check_eq("first_busy", 32'(BUSY), 32'd1);
        wait_done(10);
        next_cycle();
        REQ = '0;
        repeat (2) next_cycle();

        // Test 2: req2, LEN=6, exact cycle timing.
        LEN[2*W +: W] = 4'd6;
        REQ = 4'b0100;
        push_exp(2, 6);
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            if (c == 9) REQ = '0;
            @(negedge CLK);
            if (c <= 7) begin
                check_eq("t2_gnt", 32'(GNT), 32'b0100);
                check_eq("t2_o", 32'(O), 32'(c - 1));
            end else if (c == 8) begin
                check_eq("t2_done", 32'(DONE), 32'b0100);
                check_eq("t2_gnt_off", 32'(GNT), 32'd0);
            end else begin
                check_eq("t2_o_idle", 32'(O), 32'd0);
                check_eq("t2_busy_idle", 32'(BUSY), 32'd0);
                check_eq("t2_done_off", 32'(DONE), 32'd0);
            end
        end
        repeat (2) next_cycle();

        // Test 3: req0 and req1 held, round-robin order 0,1,0.
        LEN[0*W +: W] = 4'd1;
        LEN[1*W +: W] = 4'd2;
        REQ = 4'b0011;
        push_exp(0, 1);
        push_exp(1, 2);
        push_exp(0, 1);
        repeat (3) wait_done(20);
        next_cycle();
        REQ = '0;
        repeat (2) next_cycle();

        // Test 4: req3, LEN=15, COUT only at O=15.
        LEN[3*W +: W] = 4'd15;
        REQ = 4'b1000;
        push_exp(3, 15);
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            @(negedge CLK);
            if (c <= 16) begin
                check_eq("t4_gnt", 32'(GNT), 32'b1000);
                check_eq("t4_o", 32'(O), 32'(c - 1));
                check_eq("t4_cout", 32'(COUT), (c == 16) ? 32'd1 : 32'd0);
            end else begin
                check_eq("t4_done", 32'(DONE), 32'b1000);
                check_eq("t4_cout_off", 32'(COUT), 32'd0);
            end
        end
        next_cycle();
        REQ = '0;
        repeat (2) next_cycle();

        // Test 5: abort req1 at O=4, pending req2 granted next.
        LEN[1*W +: W] = 4'd10;
        LEN[2*W +: W] = 4'd2;
        REQ = 4'b0110;
        push_exp(2, 2);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 5) REQ = 4'b0100;
            @(negedge CLK);
            if (c <= 5) begin
                check_eq("t5_gnt", 32'(GNT), 32'b0010);
                check_eq("t5_o", 32'(O), 32'(c - 1));
            end else if (c == 6) begin
                check_eq("t5_abort_gnt", 32'(GNT), 32'd0);
                check_eq("t5_abort_o", 32'(O), 32'd0);
                check_eq("t5_abort_done", 32'(DONE), 32'd0);
                check_eq("t5_abort_busy", 32'(BUSY), 32'd0);
            end else begin
                check_eq("t5_next_gnt", 32'(GNT), 32'b0100);
                check_eq("t5_next_o", 32'(O), 32'd0);
            end
        end
        wait_done(10);
        next_cycle();
        REQ = '0;
        repeat (2) next_cycle();

        // Test 6: reset at O=5 during LEN=9 grant, fresh grant afterwards.
        LEN[0*W +: W] = 4'd9;
        REQ = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 6) RESET = 1'b1;
            if (c == 7) RESET = 1'b0;
            @(negedge CLK);
            if (c <= 6) begin
                check_eq("t6_o", 32'(O), 32'(c - 1));
            end else if (c == 7) begin
                check_eq("t6_rst_gnt", 32'(GNT), 32'd0);
                check_eq("t6_rst_o", 32'(O), 32'd0);
                check_eq("t6_rst_done", 32'(DONE), 32'd0);
                check_eq("t6_rst_busy", 32'(BUSY), 32'd0);
                check_eq("t6_rst_cout", 32'(COUT), 32'd0);
                push_exp(0, 9);
            end else begin
                check_eq("t6_regrant", 32'(GNT), 32'b0001);
                check_eq("t6_regrant_o", 32'(O), 32'd0);
            end
        end
        wait_done(20);
        next_cycle();
        REQ = '0;
        repeat (3) next_cycle();

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_time_arbiter.md
Name: counter_time_arbiter

Overview:
- Shares one 4-bit up-counter (Counter4_COUT-style datapath, counts O with carry-out COUT) between N requesters that each need a timed interval.
- Round-robin arbiter grants the counter to one requester at a time.
- The block runs the counter from 0 to the granted requester's programmed length, then returns a one-cycle DONE to that requester.
- Sits between client control FSMs and the shared counter; owns the counter register internally.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 4, counter width in bits; LEN and O are WIDTH bits

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
REQ  input  N  per-requester request level; held high until DONE or abandoned
LEN  input  N*WIDTH  per-requester terminal count; slice i = LEN[i*WIDTH +: WIDTH]
GNT  output  N  one-hot grant, high while requester owns counter
DONE  output  N  one-hot, one-cycle completion pulse
O  output  WIDTH  current counter value
COUT  output  1  high while counting and O == 2^WIDTH-1
BUSY  output  1  high in COUNT or FIN state

Behaviour:
- Interface fixed: one clock (CLK); reset (RESET) is synchronous and active-high.
- Reset: state=IDLE, GNT=0, DONE=0, O=0, COUT=0, BUSY=0, round-robin pointer=0, latched length=0. Reset wins over every other event, including mid-count; an interrupted interval produces no DONE.
- All outputs are registered (state-decoded) except COUT, which is combinational from the registered O and state.
- States: IDLE, COUNT, FIN.
- IDLE:
  - If no REQ bit is set, remain in IDLE with O=0.
  - Otherwise select the first set REQ bit scanning from pointer upward with wrap (pointer, pointer+1, ..., N-1, 0, ...).
  - Latch that requester's LEN slice and index. Next cycle: state=COUNT, GNT=onehot(winner), O=0.
- COUNT:
  - Each edge increments O by 1, no saturation logic needed since O stops at LEN <= 2^WIDTH-1.
  - On the edge where O == latched LEN: state=FIN, GNT=0, DONE=onehot(winner), O=0.
  - Grant therefore lasts LEN+1 cycles, with O showing 0..LEN. LEN=0 gives a one-cycle grant with O=0.
  - LEN changes during COUNT are ignored; only the latched value is used.
- Abort: if REQ[winner] is low in any COUNT cycle, the next edge goes to IDLE with GNT=0, O=0, and no DONE. Pointer advances as on completion. Abort has priority over completion when both occur in the same cycle.
- FIN:
  - DONE held for exactly this one cycle.
  - Next edge: state=IDLE, DONE=0, pointer=(winner+1) mod N.
  - REQ is not sampled for arbitration in FIN.
- Timing: request sampled in IDLE at cycle t. GNT and O=0 appear at t+1. DONE appears at t+LEN+2. The earliest next grant is at t+LEN+4.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 intervals.
- A requester whose REQ stays high after its DONE is treated as a new request, arbitrated against others from the advanced pointer.
- COUT: asserts only when LEN == 2^WIDTH-1 and O reaches 2^WIDTH-1. In that case COUT coincides with the final COUNT cycle.
- Invariants: GNT and DONE are each zero or one-hot and never high in the same cycle. O == 0 whenever state != COUNT.

Test Plan:
1. RESET high 2 cycles with REQ=4'b1111 → GNT=0, DONE=0, O=0, BUSY=0 throughout; after release, first grant goes to requester 0.
2. REQ[2]=1, LEN[2]=6, sampled at cycle 0 → GNT=4'b0100 at cycles 1-7 with O=0,1,...,6; DONE=4'b0100 at cycle 8 only; O=0 and BUSY=0 from cycle 9.
3. REQ=4'b0011 both held, LEN[0]=1, LEN[1]=2 → grants in order req0 (2 cycles), req1 (3 cycles), req0; DONE pulses 4'b0001, 4'b0010, 4'b0001 in that order; never two GNT bits set.
4. REQ[3]=1, LEN[3]=15 → O counts 0..15; COUT=1 only in the cycle O=15; DONE[3] pulses the following cycle.
5. REQ[1]=1, LEN[1]=10, REQ[1] dropped while O=4 → next cycle GNT=0, O=0, state IDLE, no DONE; a pending REQ[2] is granted one cycle later.
6. RESET asserted while O=5 during a LEN=9 grant → next cycle all outputs zero, no DONE ever issued for that interval; with REQ still high after release, a fresh grant restarts at O=0.
